// File: rtl/tau_counter_pkg.sv
// Shared types and constants for the up/down counter slice.
package tau_counter_pkg;

  typedef enum logic {
    MODE_WRAP     = 1'b0,
    MODE_SATURATE = 1'b1
  } counter_mode_t;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

endpackage

// File: rtl/counter_step_unit.sv
// Combinational next-value and rollover computation for one count cycle.
// The count range is 0..limit inclusive. All comparisons and sums are done
// one bit wider than the counter so that v+s and v+limit+1 never truncate.
module counter_step_unit
  import tau_counter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] value,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic             direction,
  input  counter_mode_t    mode,
  output logic [WIDTH-1:0] next_value,
  output logic             rollover
);

  logic [WIDTH:0] v_x;
  logic [WIDTH:0] l_x;
  logic [WIDTH:0] s_x;
  logic [WIDTH:0] sum_x;

  // Clamp the step to the range, then wrap or clamp the stepped value.
  always_comb begin
    v_x        = {1'b0, value};
    l_x        = {1'b0, limit};
    s_x        = (step > limit) ? l_x : {1'b0, step};
    sum_x      = v_x + s_x;
    next_value = value;
    rollover   = 1'b0;

    if (s_x == '0) begin
      // Zero effective step: hold with no event.
      next_value = value;
    end else if (v_x > l_x) begin
      // Value left stranded above a lowered limit: snap back into range.
      next_value = (mode == MODE_SATURATE) ? limit : '0;
      rollover   = 1'b1;
    end else if (direction == DIR_UP) begin
      if (sum_x > l_x) begin
        rollover   = 1'b1;
        next_value = (mode == MODE_SATURATE) ? limit
                   : WIDTH'(sum_x - (l_x + (WIDTH+1)'(1)));
      end else begin
        next_value = WIDTH'(sum_x);
      end
    end else begin
      if (s_x > v_x) begin
        rollover   = 1'b1;
        next_value = (mode == MODE_SATURATE) ? '0
                   : WIDTH'(v_x + l_x + (WIDTH+1)'(1) - s_x);
      end else begin
        next_value = WIDTH'(v_x - s_x);
      end
    end
  end

endmodule

// File: rtl/counter_updown.sv
// Up/down counter with load, wrap/saturate modes, a programmable inclusive
// upper bound, a one-cycle rollover pulse and a sticky overflow flag.
module counter_updown
  import tau_counter_pkg::*;
#(
  parameter int               WIDTH       = 8,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  input  logic             load,
  input  logic             count,
  input  logic             direction,
  input  counter_mode_t    mode,
  input  logic [WIDTH-1:0] step,
  input  logic [WIDTH-1:0] limit,
  input  logic [WIDTH-1:0] load_value,
  input  logic             clear_overflow,
  output logic [WIDTH-1:0] counter_value,
  output logic             at_bound,
  output logic             rollover,
  output logic             sticky_overflow
);

  logic [WIDTH-1:0] counter_q, counter_d;
  logic             rollover_q, rollover_d;
  logic             sticky_q, sticky_d;
  logic [WIDTH-1:0] step_next;
  logic             step_roll;

  counter_step_unit #(
    .WIDTH (WIDTH)
  ) u_step (
    .value      (counter_q),
    .step       (step),
    .limit      (limit),
    .direction  (direction),
    .mode       (mode),
    .next_value (step_next),
    .rollover   (step_roll)
  );

  // Priority: disabled holds, then load, then count, otherwise hold.
  always_comb begin
    counter_d  = counter_q;
    rollover_d = 1'b0;
    if (enable) begin
      if (load) begin
        counter_d = (load_value > limit) ? limit : load_value;
      end else if (count) begin
        counter_d  = step_next;
        rollover_d = step_roll;
      end
    end
    // A new event wins over a simultaneous clear; clear ignores enable.
    if (rollover_d) begin
      sticky_d = 1'b1;
    end else if (clear_overflow) begin
      sticky_d = 1'b0;
    end else begin
      sticky_d = sticky_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      counter_q  <= RESET_VALUE;
      rollover_q <= 1'b0;
      sticky_q   <= 1'b0;
    end else begin
      counter_q  <= counter_d;
      rollover_q <= rollover_d;
      sticky_q   <= sticky_d;
    end
  end

  assign counter_value   = counter_q;
  assign rollover        = rollover_q;
  assign sticky_overflow = sticky_q;
  assign at_bound        = (direction == DIR_UP) ? (counter_q == limit)
                                                 : (counter_q == '0);

endmodule

// File: tb/tb_counter_updown.sv
// Directed, table-driven bench for counter_updown (WIDTH=8, RESET_VALUE=0).
module tb_counter_updown;
  import tau_counter_pkg::*;

  logic          clock = 1'b0;
  logic          reset;
  logic          enable, load, count, direction, clear_overflow;
  counter_mode_t mode;
  logic [7:0]    step, limit, load_value;
  logic [7:0]    counter_value;
  logic          at_bound, rollover, sticky_overflow;

  int n_chk  = 0;
  int n_pass = 0;

  counter_updown #(.WIDTH(8), .RESET_VALUE(8'h00)) dut (
    .clock           (clock),
    .reset           (reset),
    .enable          (enable),
    .load            (load),
    .count           (count),
    .direction       (direction),
    .mode            (mode),
    .step            (step),
    .limit           (limit),
    .load_value      (load_value),
    .clear_overflow  (clear_overflow),
    .counter_value   (counter_value),
    .at_bound        (at_bound),
    .rollover        (rollover),
    .sticky_overflow (sticky_overflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic          en, ld, cnt, dir, clr;
    counter_mode_t md;
    logic [7:0]    stp, lim, lv;
    logic [7:0]    e_val;
    logic          e_roll, e_st, e_ab;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic add(input logic en, ld, cnt, dir, input counter_mode_t md,
                     input logic [7:0] stp, lim, lv, input logic clr,
                     input logic [7:0] e_val, input logic e_roll, e_st, e_ab);
    vec_t v;
    v.en = en; v.ld = ld; v.cnt = cnt; v.dir = dir; v.md = md;
    v.stp = stp; v.lim = lim; v.lv = lv; v.clr = clr;
    v.e_val = e_val; v.e_roll = e_roll; v.e_st = e_st; v.e_ab = e_ab;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, ld, cnt, dir, input counter_mode_t md,
                       input logic [7:0] stp, lim, lv, input logic clr);
    enable = en; load = ld; count = cnt; direction = dir; mode = md;
    step = stp; limit = lim; load_value = lv; clear_overflow = clr;
  endtask

  task automatic check_all(input string tag, input logic [7:0] e_val,
                           input logic e_roll, e_st, e_ab);
    chk({tag, ".value"},  32'(counter_value),   32'(e_val));
    chk({tag, ".roll"},   32'(rollover),        32'(e_roll));
    chk({tag, ".sticky"}, 32'(sticky_overflow), 32'(e_st));
    chk({tag, ".bound"},  32'(at_bound),        32'(e_ab));
  endtask

  initial begin
    // en ld cnt dir mode step lim lv clr | value roll sticky at_bound
    // Scenario 1
    add(0,1,0,1,MODE_WRAP,     8'd0, 8'hFF,8'hDE,0, 8'h00,0,0,0);
    add(1,1,0,1,MODE_WRAP,     8'd0, 8'hFF,8'hDE,0, 8'hDE,0,0,0);
    add(1,0,1,1,MODE_WRAP,     8'd2, 8'hFF,8'h00,0, 8'hE0,0,0,0);
    add(1,0,1,1,MODE_WRAP,     8'd2, 8'hFF,8'h00,0, 8'hE2,0,0,0);
    // Scenario 2
    add(1,1,0,1,MODE_WRAP,     8'd1, 8'hFF,8'hFE,0, 8'hFE,0,0,0);
    add(1,0,1,1,MODE_WRAP,     8'd1, 8'hFF,8'h00,0, 8'hFF,0,0,1);
    add(1,0,1,1,MODE_WRAP,     8'd1, 8'hFF,8'h00,0, 8'h00,1,1,0);
    add(1,0,0,1,MODE_WRAP,     8'd1, 8'hFF,8'h00,0, 8'h00,0,1,0);
    add(0,0,1,1,MODE_WRAP,     8'd1, 8'hFF,8'h00,0, 8'h00,0,1,0);
    add(0,0,0,1,MODE_WRAP,     8'd1, 8'hFF,8'h00,1, 8'h00,0,0,0);
    // Scenario 3
    add(1,1,0,1,MODE_WRAP,     8'd3, 8'd9, 8'd8, 0, 8'd8, 0,0,0);
    add(1,0,1,1,MODE_WRAP,     8'd3, 8'd9, 8'd0, 0, 8'd1, 1,1,0);
    add(1,0,1,0,MODE_WRAP,     8'd3, 8'd9, 8'd0, 0, 8'd8, 1,1,0);
    add(0,0,0,0,MODE_WRAP,     8'd3, 8'd9, 8'd0, 1, 8'd8, 0,0,0);
    // Scenario 4
    add(1,1,0,0,MODE_SATURATE, 8'd3, 8'd9, 8'd2, 0, 8'd2, 0,0,0);
    add(1,0,1,0,MODE_SATURATE, 8'd3, 8'd9, 8'd0, 0, 8'd0, 1,1,1);
    add(1,0,1,0,MODE_SATURATE, 8'd3, 8'd9, 8'd0, 0, 8'd0, 1,1,1);
    add(1,0,1,0,MODE_SATURATE, 8'd0, 8'd9, 8'd0, 0, 8'd0, 0,1,1);
    // Scenario 5
    add(1,1,0,1,MODE_WRAP,     8'd1, 8'h10,8'h20,0, 8'h10,0,1,1);
    add(1,0,1,1,MODE_WRAP,     8'd1, 8'h08,8'h00,0, 8'h00,1,1,0);
    // Over-limit in saturate mode snaps to the limit
    add(1,1,0,1,MODE_SATURATE, 8'd1, 8'h10,8'h10,0, 8'h10,0,1,1);
    add(1,0,1,0,MODE_SATURATE, 8'd1, 8'h08,8'h00,0, 8'h08,1,1,0);
    // Load wins over count
    add(1,1,1,1,MODE_WRAP,     8'd1, 8'd9, 8'd3, 0, 8'd3, 0,1,0);
    // Saturate up while already at the limit
    add(1,1,0,1,MODE_SATURATE, 8'd1, 8'd9, 8'd9, 0, 8'd9, 0,1,1);
    add(1,0,1,1,MODE_SATURATE, 8'd1, 8'd9, 8'd0, 0, 8'd9, 1,1,1);
    // Step larger than limit is clamped to limit: 9+9 wraps to 8
    add(1,0,1,1,MODE_WRAP,     8'hFF,8'd9, 8'd0, 0, 8'd8, 1,1,0);

    drive(0,0,0,1,MODE_WRAP,8'd0,8'hFF,8'h00,0);
    reset = 1'b1;
    #12;
    check_all("reset", 8'h00, 0, 0, 0);
    reset = 1'b0;
    #2;

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].ld, vecs[i].cnt, vecs[i].dir, vecs[i].md,
            vecs[i].stp, vecs[i].lim, vecs[i].lv, vecs[i].clr);
      @(posedge clock); #1;
      check_all($sformatf("v%0d", i), vecs[i].e_val, vecs[i].e_roll,
                vecs[i].e_st, vecs[i].e_ab);
    end

    // Asynchronous reset between edges while counting with sticky set.
    drive(1,1,0,1,MODE_WRAP,8'd1,8'hFF,8'h05,0);
    @(posedge clock); #1;
    drive(1,0,1,1,MODE_WRAP,8'd1,8'hFF,8'h00,0);
    @(posedge clock); #1;
    chk("midcount.value", 32'(counter_value), 32'h06);
    #2 reset = 1'b1;
    #1;
    check_all("async_rst", 8'h00, 0, 0, 0);
    #1 reset = 1'b0;
    @(posedge clock); #1;
    check_all("post_rst", 8'h01, 0, 0, 0);

    // Clear coincident with a rollover: the set wins.
    drive(1,1,0,1,MODE_WRAP,8'd1,8'hFF,8'hFF,0);
    @(posedge clock); #1;
    chk("pre_wrap.value", 32'(counter_value), 32'hFF);
    drive(1,0,1,1,MODE_WRAP,8'd1,8'hFF,8'h00,1);
    @(posedge clock); #1;
    check_all("clr_vs_set", 8'h00, 1, 1, 0);
    drive(1,0,0,1,MODE_WRAP,8'd1,8'hFF,8'h00,1);
    @(posedge clock); #1;
    check_all("clr_after", 8'h00, 0, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
